// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: parity encoding,
// FSM states, flag-bit positions and the baud divisor helper.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int FLAG_PAR  = 0;
  localparam int FLAG_FRM  = 1;
  localparam int FLAG_BRK  = 2;
  localparam int NUM_FLAGS = 3;

  localparam int GAP_BITS = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2,
    ST_RESYNC
  } rx_state_e;

  function automatic int div_round(input int clk_freq, input int baud, input int oversample);
    int den;
    int q;
    den = baud * oversample;
    q   = (clk_freq + den / 2) / den;
    return (q < 1) ? 1 : q;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through buffer for received words; a push into a full
// buffer is dropped and reported with a one-cycle overrun pulse.
module uart_rx_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             valid,
  output logic             overrun
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             overrun_q;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push is about to use.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      overrun_q <= push && !do_push;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign valid   = !empty;
  assign overrun = overrun_q;

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with majority voting, optional parity, one or
// two stop bits, break detection, line-idle tracking and an output FIFO.
//   state     | meaning
//   IDLE      | waiting for a low sample; counts idle bit times
//   START     | voting the start bit; a high vote is a glitch
//   DATA      | shifting data bits, LSB first
//   PARITY    | accumulating the parity bit
//   STOP1/2   | checking stop bits; the last one pushes the word
//   RESYNC    | after a framing error, wait for one high bit time
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 CLK50MHZ,
  input  logic                 RST_N,
  input  logic                 RxD,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [2:0]           rx_flags,
  output logic                 rx_overrun,
  output logic                 rx_idle,
  output logic                 rx_endofpacket
);

  localparam int DIV = div_round(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int WW  = DATA_BITS + NUM_FLAGS;

  localparam logic [SW-1:0] S_VA   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_VB   = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_DEC  = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [4:0]    GAP_MAX = 5'(GAP_BITS);

  logic [DW-1:0] div_q;
  logic          tick;

  always_ff @(posedge CLK50MHZ or negedge RST_N) begin
    if (!RST_N)          div_q <= '0;
    else if (div_q == '0) div_q <= DW'(DIV - 1);
    else                 div_q <= div_q - 1'b1;
  end
  assign tick = (div_q == '0);

  logic rxd_meta_q, rxd_s_q;

  always_ff @(posedge CLK50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      rxd_meta_q <= RxD;
      rxd_s_q    <= rxd_meta_q;
    end
  end

  rx_state_e            state_q, state_d;
  logic [SW-1:0]        s_cnt_q, s_cnt_d;
  logic                 v0_q, v0_d, v1_q, v1_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 zero_q, zero_d;
  logic                 ferr_q, ferr_d;
  logic [1:0]           mode_q, mode_d;
  logic                 two_q, two_d;
  logic [4:0]           gap_q, gap_d;
  logic                 seen_q, seen_d;
  logic                 eop_q, eop_d;

  logic          vote, par_en, last, push;
  logic          fin_ferr, fin_brk, fin_perr;
  logic [2:0]    fin_flags;
  logic [WW-1:0] push_word;
  logic [WW-1:0] head_word;

  assign vote   = (v0_q & v1_q) | (v0_q & rxd_s_q) | (v1_q & rxd_s_q);
  assign par_en = (mode_q == PAR_EVEN) || (mode_q == PAR_ODD);
  assign last   = (s_cnt_q == S_LAST);

  always_ff @(posedge CLK50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      s_cnt_q   <= '0;
      v0_q      <= 1'b1;
      v1_q      <= 1'b1;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      zero_q    <= 1'b0;
      ferr_q    <= 1'b0;
      mode_q    <= PAR_NONE;
      two_q     <= 1'b0;
      gap_q     <= GAP_MAX;
      seen_q    <= 1'b0;
      eop_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_cnt_q   <= s_cnt_d;
      v0_q      <= v0_d;
      v1_q      <= v1_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      zero_q    <= zero_d;
      ferr_q    <= ferr_d;
      mode_q    <= mode_d;
      two_q     <= two_d;
      gap_q     <= gap_d;
      seen_q    <= seen_d;
      eop_q     <= eop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    s_cnt_d   = s_cnt_q;
    v0_d      = v0_q;
    v1_d      = v1_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    zero_d    = zero_q;
    ferr_d    = ferr_q;
    mode_d    = mode_q;
    two_d     = two_q;
    gap_d     = gap_q;
    seen_d    = seen_q;
    eop_d     = 1'b0;
    push      = 1'b0;

    fin_ferr  = (state_q == ST_STOP2) ? (ferr_q | ~vote) : ~vote;
    fin_brk   = (state_q == ST_STOP2) ? zero_q : (zero_q & ~vote);
    fin_perr  = par_en & (par_q ^ (mode_q == PAR_ODD));
    fin_flags = '0;
    fin_flags[FLAG_BRK] = fin_brk;
    fin_flags[FLAG_FRM] = fin_ferr;
    fin_flags[FLAG_PAR] = fin_perr;
    push_word = {shreg_q, fin_flags};

    if (tick) begin
      s_cnt_d = last ? '0 : s_cnt_q + 1'b1;
      if (s_cnt_q == S_VA) v0_d = rxd_s_q;
      if (s_cnt_q == S_VB) v1_d = rxd_s_q;

      case (state_q)
        ST_IDLE: begin
          if (!rxd_s_q) begin
            // The detecting tick is sample 0 of the start bit.
            state_d   = ST_START;
            s_cnt_d   = SW'(1);
            mode_d    = parity_mode;
            two_d     = two_stop;
            gap_d     = '0;
            bit_idx_d = '0;
            par_d     = 1'b0;
            zero_d    = 1'b1;
            ferr_d    = 1'b0;
          end else if (last && gap_q != GAP_MAX) begin
            gap_d = gap_q + 1'b1;
            if (gap_q == GAP_MAX - 1'b1 && seen_q) begin
              eop_d  = 1'b1;
              seen_d = 1'b0;
            end
          end
        end
        ST_START: begin
          if (s_cnt_q == S_DEC && vote) begin
            state_d = ST_IDLE;
            s_cnt_d = '0;
          end else if (last) begin
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          if (s_cnt_q == S_DEC) begin
            shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
            par_d   = par_q ^ vote;
            zero_d  = zero_q & ~vote;
          end else if (last) begin
            if (bit_idx_q == 4'(DATA_BITS - 1)) begin
              bit_idx_d = '0;
              state_d   = par_en ? ST_PARITY : ST_STOP1;
            end else begin
              bit_idx_d = bit_idx_q + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (s_cnt_q == S_DEC) begin
            par_d  = par_q ^ vote;
            zero_d = zero_q & ~vote;
          end else if (last) begin
            state_d = ST_STOP1;
          end
        end
        ST_STOP1, ST_STOP2: begin
          if (s_cnt_q == S_DEC) begin
            ferr_d = fin_ferr;
            zero_d = fin_brk;
            if (state_q == ST_STOP2 || !two_q) begin
              push    = 1'b1;
              seen_d  = 1'b1;
              s_cnt_d = '0;
              state_d = fin_ferr ? ST_RESYNC : ST_IDLE;
            end
          end else if (last) begin
            state_d = ST_STOP2;
          end
        end
        ST_RESYNC: begin
          if (!rxd_s_q)  s_cnt_d = '0;
          else if (last) state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          s_cnt_d = '0;
        end
      endcase
    end
  end

  uart_rx_fifo #(
    .WIDTH (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK50MHZ),
    .rst_n     (RST_N),
    .push      (push),
    .push_data (push_word),
    .pop       (rx_ready),
    .rd_data   (head_word),
    .valid     (rx_valid),
    .overrun   (rx_overrun)
  );

  assign rx_data        = head_word[WW-1:NUM_FLAGS];
  assign rx_flags       = head_word[NUM_FLAGS-1:0];
  assign rx_idle        = (gap_q == GAP_MAX);
  assign rx_endofpacket = eop_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8-bit and a 7-bit instance driven by
// a table of frames plus hand-written glitch, break, overrun and reset cases.
module tb_uart_rx_param;

  localparam int BITC = 16;  // clocks per bit: DIV=2, OVERSAMPLE=8

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       rxd_a = 1'b1, ts_a = 1'b0, rdy_a = 1'b1;
  logic [1:0] pm_a  = 2'b00;
  logic [7:0] data_a;
  logic [2:0] fl_a;
  logic       val_a, ovr_a, idle_a, eop_a;

  logic       rxd_b = 1'b1, ts_b = 1'b0, rdy_b = 1'b1;
  logic [1:0] pm_b  = 2'b00;
  logic [6:0] data_b;
  logic [2:0] fl_b;
  logic       val_b, ovr_b, idle_b, eop_b;

  uart_rx_param #(.CLK_FREQ(1600), .BAUD(100), .DATA_BITS(8), .OVERSAMPLE(8), .FIFO_DEPTH(4)) dut_a (
    .CLK50MHZ(clk), .RST_N(rst_n), .RxD(rxd_a), .parity_mode(pm_a), .two_stop(ts_a),
    .rx_data(data_a), .rx_valid(val_a), .rx_ready(rdy_a), .rx_flags(fl_a),
    .rx_overrun(ovr_a), .rx_idle(idle_a), .rx_endofpacket(eop_a));

  uart_rx_param #(.CLK_FREQ(1600), .BAUD(100), .DATA_BITS(7), .OVERSAMPLE(8), .FIFO_DEPTH(4)) dut_b (
    .CLK50MHZ(clk), .RST_N(rst_n), .RxD(rxd_b), .parity_mode(pm_b), .two_stop(ts_b),
    .rx_data(data_b), .rx_valid(val_b), .rx_ready(rdy_b), .rx_flags(fl_b),
    .rx_overrun(ovr_b), .rx_idle(idle_b), .rx_endofpacket(eop_b));

  typedef struct {
    logic [8:0] d;
    logic [2:0] f;
  } cap_t;

  typedef struct {
    int         sel;
    logic [8:0] d;
    int         nb;
    logic [1:0] pm;
    logic       two;
    logic       flip;
    logic       s1;
    logic       s2;
    logic [8:0] ed;
    logic [2:0] ef;
  } vec_t;

  cap_t cap_a[$];
  cap_t cap_b[$];
  int   cyc = 0;
  int   ovr_cnt = 0;
  int   eop_cnt = 0;
  int   t_eop = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    cap_t c;
    if (rst_n) begin
      if (val_a && rdy_a) begin
        c.d = {1'b0, data_a};
        c.f = fl_a;
        cap_a.push_back(c);
      end
      if (val_b && rdy_b) begin
        c.d = {2'b00, data_b};
        c.f = fl_b;
        cap_b.push_back(c);
      end
      if (ovr_a) ovr_cnt++;
      if (eop_a) begin
        eop_cnt++;
        t_eop = cyc;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic hold_bits(input int n);
    repeat (n * BITC) @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int sel, input logic v);
    if (sel == 0) rxd_a = v;
    else          rxd_b = v;
  endtask

  task automatic set_cfg(input int sel, input logic [1:0] pm, input logic two);
    if (sel == 0) begin pm_a = pm; ts_a = two; end
    else          begin pm_b = pm; ts_b = two; end
  endtask

  // Config is inverted after the start bit to show it is latched at frame start.
  task automatic send_frame(input int sel, input logic [8:0] d, input int nb, input logic [1:0] pm,
                            input logic two, input logic flip, input logic s1, input logic s2);
    logic par;
    par = 1'b0;
    set_cfg(sel, pm, two);
    set_line(sel, 1'b0);
    hold_bits(1);
    set_cfg(sel, ~pm, ~two);
    for (int i = 0; i < nb; i++) begin
      par = par ^ d[i];
      set_line(sel, d[i]);
      hold_bits(1);
    end
    if (pm == 2'b01 || pm == 2'b10) begin
      set_line(sel, par ^ (pm == 2'b10) ^ flip);
      hold_bits(1);
    end
    set_line(sel, s1);
    hold_bits(1);
    if (two) begin
      set_line(sel, s2);
      hold_bits(1);
    end
    set_line(sel, 1'b1);
    set_cfg(sel, pm, two);
  endtask

  task automatic check_word(input int sel, input int idx, input string name,
                            input logic [8:0] ed, input logic [2:0] ef);
    int sz;
    sz = (sel == 0) ? cap_a.size() : cap_b.size();
    check({name, "_count"}, sz, idx + 1);
    if (sz > idx) begin
      if (sel == 0) begin
        check({name, "_data"},  cap_a[idx].d, ed);
        check({name, "_flags"}, cap_a[idx].f, ef);
      end else begin
        check({name, "_data"},  cap_b[idx].d, ed);
        check({name, "_flags"}, cap_b[idx].f, ef);
      end
    end
  endtask

  vec_t vecs[13];

  initial begin
    int   base;
    int   ovr0;
    int   eop0;
    int   t_end;
    int   dly;
    logic [7:0] pat;

    vecs[0]  = '{0, 9'h0A5, 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 9'h0A5, 3'b000};
    vecs[1]  = '{0, 9'h03C, 8, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 9'h03C, 3'b000};
    vecs[2]  = '{0, 9'h03C, 8, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 9'h03C, 3'b000};
    vecs[3]  = '{0, 9'h081, 8, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 9'h081, 3'b001};
    vecs[4]  = '{0, 9'h0FF, 8, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 9'h0FF, 3'b000};
    vecs[5]  = '{0, 9'h000, 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 9'h000, 3'b000};
    vecs[6]  = '{0, 9'h055, 8, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 9'h055, 3'b010};
    vecs[7]  = '{0, 9'h000, 8, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 9'h000, 3'b110};
    vecs[8]  = '{0, 9'h012, 8, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 9'h012, 3'b010};
    vecs[9]  = '{1, 9'h035, 7, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1, 9'h035, 3'b001};
    vecs[10] = '{1, 9'h035, 7, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 9'h035, 3'b000};
    vecs[11] = '{1, 9'h07F, 7, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 9'h07F, 3'b000};
    vecs[12] = '{0, 9'h0C3, 8, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 9'h0C3, 3'b001};

    repeat (4) @(posedge clk);
    #1;
    check("rst_valid_a",    val_a,  1'b0);
    check("rst_data_a",     data_a, 8'h00);
    check("rst_flags_a",    fl_a,   3'b000);
    check("rst_overrun_a",  ovr_a,  1'b0);
    check("rst_eop_a",      eop_a,  1'b0);
    check("rst_idle_a",     idle_a, 1'b1);
    check("rst_valid_b",    val_b,  1'b0);
    check("rst_idle_b",     idle_b, 1'b1);
    rst_n = 1'b1;
    hold_bits(2);

    for (int i = 0; i < 13; i++) begin
      base = (vecs[i].sel == 0) ? cap_a.size() : cap_b.size();
      send_frame(vecs[i].sel, vecs[i].d, vecs[i].nb, vecs[i].pm, vecs[i].two,
                 vecs[i].flip, vecs[i].s1, vecs[i].s2);
      hold_bits(3);
      check_word(vecs[i].sel, base, $sformatf("vec%0d", i), vecs[i].ed, vecs[i].ef);
    end

    // Start-bit glitch: low for three ticks only.
    base = cap_a.size();
    set_cfg(0, 2'b00, 1'b0);
    set_line(0, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    set_line(0, 1'b1);
    hold_bits(3);
    check("glitch_no_push", cap_a.size(), base);
    send_frame(0, 9'h05A, 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    hold_bits(3);
    check_word(0, base, "after_glitch", 9'h05A, 3'b000);

    // Break: line low for 12 bit times.
    base = cap_a.size();
    set_line(0, 1'b0);
    hold_bits(12);
    set_line(0, 1'b1);
    hold_bits(3);
    check_word(0, base, "break", 9'h000, 3'b110);
    hold_bits(5);
    check("break_single_word", cap_a.size(), base + 1);

    // Overrun with a stalled consumer, then idle / end-of-packet timing.
    hold_bits(20);
    check("idle_before_burst", idle_a, 1'b1);
    ovr0  = ovr_cnt;
    eop0  = eop_cnt;
    base  = cap_a.size();
    rdy_a = 1'b0;
    for (int k = 1; k <= 5; k++) send_frame(0, 9'(k), 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    t_end = cyc;
    hold_bits(20);
    check("overrun_pulses", ovr_cnt - ovr0, 1);
    check("eop_pulses", eop_cnt - eop0, 1);
    dly = t_eop - t_end;
    if (!(dly >= 14 * BITC && dly <= 17 * BITC))
      $display("eop delay %0d clocks after last stop bit", dly);
    check("eop_delay_in_window", (dly >= 14 * BITC && dly <= 17 * BITC), 1'b1);
    check("full_valid", val_a, 1'b1);
    check("no_pop_while_stalled", cap_a.size(), base);
    rdy_a = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("drain_count", cap_a.size(), base + 4);
    for (int k = 0; k < 4; k++) begin
      if (cap_a.size() > base + k) begin
        check($sformatf("drain%0d_data", k),  cap_a[base + k].d, 9'(k + 1));
        check($sformatf("drain%0d_flags", k), cap_a[base + k].f, 3'b000);
      end
    end
    check("drained_valid", val_a, 1'b0);
    check("idle_after_burst", idle_a, 1'b1);

    // Reset asserted during data bit 4 of a frame.
    base = cap_a.size();
    pat  = 8'h77;
    set_line(0, 1'b0);
    hold_bits(1);
    for (int i = 0; i < 4; i++) begin
      set_line(0, pat[i]);
      hold_bits(1);
    end
    set_line(0, pat[4]);
    rst_n = 1'b0;
    hold_bits(1);
    set_line(0, 1'b1);
    hold_bits(1);
    check("midrst_valid", val_a, 1'b0);
    check("midrst_idle", idle_a, 1'b1);
    rst_n = 1'b1;
    hold_bits(2);
    send_frame(0, 9'h03C, 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    hold_bits(3);
    check_word(0, base, "after_reset", 9'h03C, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
